seg_disp_sched: RTL and testbench



---
 rtl/seg_disp_pkg.sv | 18 +
 rtl/seg_rr_pick.sv | 27 ++
 rtl/seg_disp_sched.sv | 201 ++++++++++++++++++++
 tb/tb_seg_disp_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seg_led display scheduler.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShow  = 2'd1,
    StBlank = 2'd2
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'd3;
  localparam int unsigned NSRC = 3;

  // Next source index in round-robin order, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, last and returns
// the first requester.
module seg_rr_pick
  import seg_disp_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = OWNER_NONE;
    cand  = last;
    for (int unsigned i = 0; i < NSRC; i++) begin
      cand = rr_next(cand);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares one seg_led driver between three sources: round-robin grant,
// minimum dwell per owner, blank gap between owners, and an owner lock.
module seg_disp_sched
  import seg_disp_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DWELL_MS = 1000,
  parameter int unsigned BLANK_MS = 100
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  req,
  input  logic        lock,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  input  logic [5:0]  point0,
  input  logic [5:0]  point1,
  input  logic [5:0]  point2,
  input  logic        en0,
  input  logic        en1,
  input  logic        en2,
  input  logic        sign0,
  input  logic        sign1,
  input  logic        sign2,
  output logic [2:0]  grant,
  output logic [1:0]  owner,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        en,
  output logic        sign
);

  localparam int unsigned DWELL_CYC = CLK_FREQ / 1000 * DWELL_MS;
  localparam int unsigned BLANK_CYC = CLK_FREQ / 1000 * BLANK_MS;
  localparam int unsigned DWELL_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYC - 1);
  localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYC - 1);

  state_e             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [2:0]         grant_q, grant_d;
  logic [1:0]         owner_q, owner_d;
  logic [19:0]        data_q, data_d;
  logic [5:0]         point_q, point_d;
  logic               en_q, en_d;
  logic               sign_q, sign_d;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [19:0] src_data;
  logic [5:0]  src_point;
  logic        src_en;
  logic        src_sign;
  logic        own_req;
  logic        other_req;
  logic        dwell_sat;

  seg_rr_pick u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    src_data  = '0;
    src_point = '0;
    src_en    = 1'b0;
    src_sign  = 1'b0;
    case (owner_q)
      2'd0: begin
        src_data = data0; src_point = point0; src_en = en0; src_sign = sign0;
      end
      2'd1: begin
        src_data = data1; src_point = point1; src_en = en1; src_sign = sign1;
      end
      2'd2: begin
        src_data = data2; src_point = point2; src_en = en2; src_sign = sign2;
      end
      default: ;
    endcase
  end

  // grant_q is one-hot on the owner while showing, so it splits req cleanly.
  assign own_req   = |(req & grant_q);
  assign other_req = |(req & ~grant_q);
  assign dwell_sat = (dwell_q == DWELL_MAX);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    grant_d = grant_q;
    owner_d = owner_q;
    data_d  = data_q;
    point_d = point_q;
    en_d    = en_q;
    sign_d  = sign_q;

    case (state_q)
      StIdle: begin
        en_d    = 1'b0;
        grant_d = '0;
        owner_d = OWNER_NONE;
        if (pick_valid) begin
          state_d = StShow;
          last_d  = pick_idx;
          owner_d = pick_idx;
          grant_d = 3'b001 << pick_idx;
          dwell_d = '0;
        end
      end

      StShow: begin
        if (!own_req) begin
          state_d = other_req ? StBlank : StIdle;
        end else if (dwell_sat && !lock && other_req) begin
          state_d = StBlank;
        end
        if (state_d == StShow) begin
          data_d  = src_data;
          point_d = src_point;
          en_d    = src_en;
          sign_d  = src_sign;
          if (!dwell_sat) begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end else begin
          en_d    = 1'b0;
          grant_d = '0;
          owner_d = OWNER_NONE;
          dwell_d = '0;
          blank_d = '0;
        end
      end

      StBlank: begin
        if (blank_q == BLANK_MAX) begin
          blank_d = '0;
          if (pick_valid) begin
            state_d = StShow;
            last_d  = pick_idx;
            owner_d = pick_idx;
            grant_d = 3'b001 << pick_idx;
            dwell_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          blank_d = blank_q + BLANK_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
        owner_d = OWNER_NONE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      last_q  <= 2'd2;
      dwell_q <= '0;
      blank_q <= '0;
      grant_q <= '0;
      owner_q <= OWNER_NONE;
      data_q  <= '0;
      point_q <= '0;
      en_q    <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      point_q <= point_d;
      en_q    <= en_d;
      sign_q  <= sign_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign data  = data_q;
  assign point = point_q;
  assign en    = en_q;
  assign sign  = sign_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched with a cycle-level reference model
// built from the scheduling rules (DWELL_CYC=8, BLANK_CYC=2).
module tb_seg_disp_sched;

  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic        lock = 1'b0;
  logic [19:0] d_src [3];
  logic [5:0]  p_src [3];
  logic        e_src [3];
  logic        s_src [3];
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic [19:0] data;
  logic [5:0]  point;
  logic        en;
  logic        sign;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: mode 0 idle, 1 showing m_own, 2 blanking.
  int          m_mode, m_own, m_last, m_shown, m_blanked;
  logic [19:0] x_data;
  logic [5:0]  x_point;
  logic        x_en, x_sign;

  seg_disp_sched #(
    .CLK_FREQ (1000),
    .DWELL_MS (8),
    .BLANK_MS (2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .lock    (lock),
    .data0   (d_src[0]),
    .data1   (d_src[1]),
    .data2   (d_src[2]),
    .point0  (p_src[0]),
    .point1  (p_src[1]),
    .point2  (p_src[2]),
    .en0     (e_src[0]),
    .en1     (e_src[1]),
    .en2     (e_src[2]),
    .sign0   (s_src[0]),
    .sign1   (s_src[1]),
    .sign2   (s_src[2]),
    .grant   (grant),
    .owner   (owner),
    .data    (data),
    .point   (point),
    .en      (en),
    .sign    (sign)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int rr_pick(logic [2:0] r, int last);
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = (last + i) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int         w;
    logic [2:0] mine;
    bit         others;
    if (sys_rst) begin
      m_mode = 0; m_own = -1; m_last = 2; m_shown = 0; m_blanked = 0;
      x_data = '0; x_point = '0; x_en = 1'b0; x_sign = 1'b0;
      return;
    end
    case (m_mode)
      0: begin
        x_en = 1'b0;
        w = rr_pick(req, m_last);
        if (w >= 0) begin
          m_mode = 1; m_own = w; m_last = w; m_shown = 0;
        end
      end
      1: begin
        mine   = 3'(1 << m_own);
        others = |(req & ~mine);
        if (!req[m_own]) m_mode = others ? 2 : 0;
        else if (m_shown >= DWELL - 1 && !lock && others) m_mode = 2;
        if (m_mode == 1) begin
          x_data  = d_src[m_own];
          x_point = p_src[m_own];
          x_en    = e_src[m_own];
          x_sign  = s_src[m_own];
          if (m_shown < DWELL - 1) m_shown++;
        end else begin
          x_en = 1'b0; m_own = -1; m_blanked = 0;
        end
      end
      default: begin
        if (m_blanked == BLANK - 1) begin
          m_blanked = 0;
          w = rr_pick(req, m_last);
          if (w >= 0) begin
            m_mode = 1; m_own = w; m_last = w; m_shown = 0;
          end else begin
            m_mode = 0;
          end
        end else begin
          m_blanked++;
        end
      end
    endcase
  endtask

  function automatic logic [32:0] exp_vec();
    logic [2:0] g;
    logic [1:0] o;
    g = (m_mode == 1) ? 3'(1 << m_own) : 3'b000;
    o = (m_mode == 1) ? 2'(m_own) : 2'd3;
    return {g, o, x_en, x_sign, x_point, x_data};
  endfunction

  function automatic logic [32:0] obs_vec();
    return {grant, owner, en, sign, point, data};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    model_step();
  endtask

  task automatic rand_src();
    for (int k = 0; k < 3; k++) begin
      d_src[k] = 20'($urandom);
      p_src[k] = 6'($urandom);
      e_src[k] = 1'($urandom);
      s_src[k] = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; req = 3'b111; lock = 1'b0;
    rand_src();
    tick(); tick();
    checks++;
    if ({grant, owner, en, data} !== {3'b000, 2'd3, 1'b0, 20'd0}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", {grant, owner, en, data},
               {3'b000, 2'd3, 1'b0, 20'd0});
    end
    sys_rst = 1'b0;
    tick();
    checks++;
    if (grant !== 3'b001) begin
      errors++; $display("FAIL reset_first_grant got=%b want=001", grant);
    end
    tick();
    checks++;
    if (data !== d_src[0]) begin
      errors++; $display("FAIL reset_first_data got=%h want=%h", data, d_src[0]);
    end
  endtask

  task automatic test_single();
    req = 3'b000;
    tick(); tick();
    req = 3'b010;
    d_src[1] = 20'h12345;
    for (int i = 0; i < 30; i++) begin
      p_src[1] = 6'($urandom); e_src[1] = 1'($urandom); s_src[1] = 1'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      checks++;
      if (owner !== 2'd1) begin
        errors++; $display("FAIL single_owner cyc=%0d got=%0d want=1", cyc, owner);
      end
    end
    checks++;
    if (data !== 20'h12345) begin
      errors++; $display("FAIL single_data got=%h want=12345", data);
    end
  endtask

  task automatic test_rotation();
    int         p;
    logic [1:0] want;
    req = 3'b111;
    for (int i = 0; i < 62; i++) begin
      rand_src();
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rotation_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      // Owner 1 had saturated dwell, so: 2 blank cycles, then 8-on / 2-off from owner 2.
      p    = i - 2;
      want = (p < 0 || p % 10 >= 8) ? 2'd3 : 2'((2 + p / 10) % 3);
      checks++;
      if (owner !== want) begin
        errors++; $display("FAIL rotation_owner cyc=%0d got=%0d want=%0d", cyc, owner, want);
      end
    end
  endtask

  task automatic test_lock();
    int budget = 0;
    req = 3'b111;
    while (owner !== 2'd0 && budget < 30) begin
      tick();
      budget++;
    end
    checks++;
    if (owner !== 2'd0) begin
      errors++; $display("FAIL lock_reach_owner0 got=%0d want=0", owner);
    end
    lock = 1'b1; req = 3'b011;
    for (int i = 0; i < 40; i++) begin
      rand_src();
      tick();
      checks++;
      if (owner !== 2'd0 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lock_hold cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    lock = 1'b0;
    tick();
    checks++;
    if (owner !== 2'd3 || en !== 1'b0) begin
      errors++; $display("FAIL lock_release_blank got=%0d/%b want=3/0", owner, en);
    end
    tick();
    tick();
    checks++;
    if (owner !== 2'd1) begin
      errors++; $display("FAIL lock_next_owner got=%0d want=1", owner);
    end
  endtask

  task automatic test_early_release();
    req = 3'b100;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (owner !== 2'd2) begin
      errors++; $display("FAIL early_owner2 got=%0d want=2", owner);
    end
    req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (owner !== ((i < 2) ? 2'd3 : 2'd0) || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL early_to_blank cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    req = 3'b100;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (owner !== 2'd2) begin
      errors++; $display("FAIL early_owner2_again got=%0d want=2", owner);
    end
    req = 3'b000;
    tick();
    req = 3'b001;
    tick();
    // Only a direct drop to idle lets source 0 win on the very next cycle.
    checks++;
    if (owner !== 2'd0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL early_to_idle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_blank();
    tick();
    req = 3'b010;
    tick();
    checks++;
    if (owner !== 2'd3) begin
      errors++; $display("FAIL rstblank_enter got=%0d want=3", owner);
    end
    sys_rst = 1'b1;
    tick();
    checks++;
    if ({grant, owner, en, point, data} !== {3'b000, 2'd3, 1'b0, 6'd0, 20'd0}) begin
      errors++; $display("FAIL rstblank_state got=%h", {grant, owner, en, point, data});
    end
    sys_rst = 1'b0;
    req = 3'b110;
    tick();
    checks++;
    if (owner !== 2'd1 || grant !== 3'b010) begin
      errors++; $display("FAIL rstblank_regrant got=%0d/%b want=1/010", owner, grant);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) req = 3'($urandom);
      if ($urandom_range(0, 19) == 0) lock = ~lock;
      sys_rst = ($urandom_range(0, 149) == 0);
      rand_src();
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_lock();
    test_early_release();
    test_reset_blank();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
